// File: rtl/bsc_axiu_stream_rr_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS AXI-Stream inputs into
// one output stream. A port keeps the grant from its first beat through the
// beat carrying tlast. With USE_BUFFER=1 a 2-entry skid FIFO registers the
// output so no combinational path links the input and output handshakes.
module bsc_axiu_stream_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int TID_WIDTH  = 4,
    parameter bit USE_BUFFER = 1'b0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NUM_PORTS*64-1:0]        in_tdata,
    input  logic [NUM_PORTS*3-1:0]         in_tdest,
    input  logic [NUM_PORTS*TID_WIDTH-1:0] in_tid,
    input  logic [NUM_PORTS-1:0]           in_tlast,
    input  logic [NUM_PORTS-1:0]           in_tvalid,
    output logic [NUM_PORTS-1:0]           in_tready,
    output logic [63:0]                    out_tdata,
    output logic [2:0]                     out_tdest,
    output logic [TID_WIDTH-1:0]           out_tid,
    output logic                           out_tlast,
    output logic                           out_tvalid,
    input  logic                           out_tready,
    output logic [NUM_PORTS-1:0]           grant
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    typedef struct packed {
        logic [63:0]          data;
        logic [2:0]           dest;
        logic [TID_WIDTH-1:0] tid;
        logic                 last;
    } beat_t;

    state_t               state, state_next;
    logic [PTR_W-1:0]     ptr, ptr_next;
    logic [NUM_PORTS-1:0] grant_next;
    logic [PTR_W-1:0]     gidx;
    beat_t                mux_beat;
    logic                 mux_valid;
    logic                 dn_ready;
    logic                 in_hs;

    // Decode the granted index and steer that port's beat onto the mux output.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value held and no latch is inferred.
    always_comb begin
        gidx      = '0;
        mux_beat  = '0;
        mux_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                gidx          = PTR_W'(i);
                mux_beat.data = in_tdata[64*i +: 64];
                mux_beat.dest = in_tdest[3*i +: 3];
                mux_beat.tid  = in_tid[TID_WIDTH*i +: TID_WIDTH];
                mux_beat.last = in_tlast[i];
                mux_valid     = in_tvalid[i];
            end
        end
    end

    assign in_hs = mux_valid & dn_ready;

    // State register: FSM state, round-robin pointer and the one-hot grant.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            grant <= grant_next;
        end
    end

    // Next state: pick the first requester from ptr in IDLE, release on tlast.
    always_comb begin
        int sel;
        sel        = 0;
        state_next = state;
        ptr_next   = ptr;
        grant_next = grant;
        case (state)
            IDLE: begin
                if (|in_tvalid) begin
                    // Scan downward so the candidate closest to ptr wins last.
                    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                        if (in_tvalid[(int'(ptr) + k) % NUM_PORTS]) begin
                            sel = (int'(ptr) + k) % NUM_PORTS;
                        end
                    end
                    state_next = LOCKED;
                    grant_next = NUM_PORTS'(1) << sel;
                end
            end
            LOCKED: begin
                if (in_hs && mux_beat.last) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = PTR_W'((int'(gidx) + 1) % NUM_PORTS);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Outputs: only the granted port sees downstream ready, and only in LOCKED.
    always_comb begin
        in_tready = '0;
        if (state == LOCKED) begin
            in_tready = grant & {NUM_PORTS{dn_ready}};
        end
    end

    if (USE_BUFFER) begin : g_skid
        beat_t      mem [2];
        logic       wr_ptr, rd_ptr;
        logic [1:0] count;
        logic       push, pop;

        assign dn_ready = (count != 2'd2);
        assign push     = mux_valid & dn_ready;
        assign pop      = (count != 2'd0) & out_tready;

        // Skid FIFO: two entries in order, push and pop may happen together.
        // NOTE: the storage is reset as well so the output fields read zero
        // after reset instead of leftover contents.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                mem[0] <= '0;
                mem[1] <= '0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= mux_beat;
                end
                wr_ptr <= wr_ptr ^ push;
                rd_ptr <= rd_ptr ^ pop;
                count  <= count + 2'(push) - 2'(pop);
            end
        end

        assign out_tvalid = (count != 2'd0);
        assign out_tdata  = mem[rd_ptr].data;
        assign out_tdest  = mem[rd_ptr].dest;
        assign out_tid    = mem[rd_ptr].tid;
        assign out_tlast  = mem[rd_ptr].last;
    end else begin : g_direct
        assign dn_ready   = out_tready;
        assign out_tvalid = mux_valid;
        assign out_tdata  = mux_beat.data;
        assign out_tdest  = mux_beat.dest;
        assign out_tid    = mux_beat.tid;
        assign out_tlast  = mux_beat.last;
    end

endmodule

// File: tb/tb_bsc_axiu_stream_rr_arbiter.sv
// Bench for bsc_axiu_stream_rr_arbiter: one unbuffered and one buffered
// instance, each checked every cycle against a queue-based reference model of
// packet arbitration and the 2-entry output FIFO.
module tb_bsc_axiu_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;

    typedef struct packed {
        logic [63:0]   data;
        logic [2:0]    dest;
        logic [TW-1:0] tid;
        logic          last;
    } beat_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    logic [N*64-1:0] in_tdata  [2];
    logic [N*3-1:0]  in_tdest  [2];
    logic [N*TW-1:0] in_tid    [2];
    logic [N-1:0]    in_tlast  [2];
    logic [N-1:0]    in_tvalid [2];
    logic [N-1:0]    in_tready [2];
    logic [63:0]     out_tdata [2];
    logic [2:0]      out_tdest [2];
    logic [TW-1:0]   out_tid   [2];
    logic            out_tlast [2];
    logic            out_tvalid[2];
    logic            out_tready[2];
    logic [N-1:0]    grant     [2];

    always #5 aclk = ~aclk;

    bsc_axiu_stream_rr_arbiter #(.NUM_PORTS(N), .TID_WIDTH(TW), .USE_BUFFER(1'b0)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .in_tdata(in_tdata[0]), .in_tdest(in_tdest[0]), .in_tid(in_tid[0]),
        .in_tlast(in_tlast[0]), .in_tvalid(in_tvalid[0]), .in_tready(in_tready[0]),
        .out_tdata(out_tdata[0]), .out_tdest(out_tdest[0]), .out_tid(out_tid[0]),
        .out_tlast(out_tlast[0]), .out_tvalid(out_tvalid[0]), .out_tready(out_tready[0]),
        .grant(grant[0])
    );

    bsc_axiu_stream_rr_arbiter #(.NUM_PORTS(N), .TID_WIDTH(TW), .USE_BUFFER(1'b1)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .in_tdata(in_tdata[1]), .in_tdest(in_tdest[1]), .in_tid(in_tid[1]),
        .in_tlast(in_tlast[1]), .in_tvalid(in_tvalid[1]), .in_tready(in_tready[1]),
        .out_tdata(out_tdata[1]), .out_tdest(out_tdest[1]), .out_tid(out_tid[1]),
        .out_tlast(out_tlast[1]), .out_tvalid(out_tvalid[1]), .out_tready(out_tready[1]),
        .grant(grant[1])
    );

    // Sources: per (instance, port) queue of beats still to be offered.
    beat_t       src_q [2*N][$];
    bit          vld   [2*N];
    int          stall [2*N];
    int          pkt_cnt;
    int          loaded[2];

    // Reference model: packet owner, pointer and the skid FIFO as a queue.
    bit          m_lock[2];
    int          m_ptr [2];
    int          m_g   [2];
    beat_t       fq    [2][$];

    // Observations of what actually left each DUT.
    logic [64:0] obs_q  [2][$];
    int          order_q[2][$];
    int          out_cyc[$];
    int          exp_ord[$];

    int vld_pct, rdy_pct, rdy_mode, cyc, req_cyc;
    int n_cmp, n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic add_pkt(input int b, input int p, input int nb);
        beat_t bt;
        for (int k = 0; k < nb; k++) begin
            bt.data = {4'(p), 12'(pkt_cnt), 16'(k), 32'($urandom())};
            bt.dest = 3'($urandom());
            bt.tid  = TW'($urandom());
            bt.last = (k == nb - 1);
            src_q[b*N+p].push_back(bt);
        end
        loaded[b] += nb;
        pkt_cnt++;
    endtask

    task automatic clear_logs();
        for (int b = 0; b < 2; b++) begin
            obs_q[b].delete();
            order_q[b].delete();
            loaded[b] = 0;
        end
        out_cyc.delete();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2*N; i++) begin
            src_q[i].delete();
            vld[i]   = 1'b0;
            stall[i] = 0;
        end
        for (int b = 0; b < 2; b++) begin
            m_lock[b]    = 1'b0;
            m_ptr[b]     = 0;
            m_g[b]       = 0;
            fq[b].delete();
            in_tvalid[b] = '0;
        end
        clear_logs();
    endtask

    function automatic bit busy();
        busy = 1'b0;
        for (int i = 0; i < 2*N; i++) if (src_q[i].size() != 0) busy = 1'b1;
        for (int b = 0; b < 2; b++) if (m_lock[b] || fq[b].size() != 0) busy = 1'b1;
    endfunction

    // Compare one instance against the model, then advance the model one edge.
    task automatic model_cycle(input int b);
        int       g, idx, sel;
        bit       dn, mvalid, ev, in_hs, found;
        logic [N-1:0] eg, er;
        beat_t    gb, eb;
        g      = m_g[b];
        idx    = b*N + g;
        dn     = (b == 1) ? (fq[b].size() < 2) : out_tready[b];
        eg     = m_lock[b] ? (N'(1) << g) : '0;
        er     = (m_lock[b] && dn) ? eg : '0;
        mvalid = m_lock[b] && vld[idx];
        gb     = mvalid ? src_q[idx][0] : '0;
        if (b == 0) begin
            ev = mvalid;
            eb = gb;
        end else begin
            ev = (fq[b].size() > 0);
            eb = ev ? fq[b][0] : '0;
        end
        check($sformatf("grant%0d", b), 64'(grant[b]), 64'(eg));
        check($sformatf("in_tready%0d", b), 64'(in_tready[b]), 64'(er));
        check($sformatf("out_tvalid%0d", b), 64'(out_tvalid[b]), 64'(ev));
        if (ev) begin
            check($sformatf("out_tdata%0d", b), out_tdata[b], eb.data);
            check($sformatf("out_tdest%0d", b), 64'(out_tdest[b]), 64'(eb.dest));
            check($sformatf("out_tid%0d", b), 64'(out_tid[b]), 64'(eb.tid));
            check($sformatf("out_tlast%0d", b), 64'(out_tlast[b]), 64'(eb.last));
        end
        if (out_tvalid[b] && out_tready[b]) begin
            obs_q[b].push_back({out_tlast[b], out_tdata[b]});
            if (out_tlast[b]) order_q[b].push_back(int'(out_tdata[b][63:60]));
            if (b == 1) out_cyc.push_back(cyc);
        end
        in_hs = mvalid && dn;
        if (b == 1 && ev && out_tready[b]) void'(fq[b].pop_front());
        if (b == 1 && in_hs) fq[b].push_back(gb);
        if (in_hs) begin
            void'(src_q[idx].pop_front());
            vld[idx] = 1'b0;
        end
        if (!m_lock[b]) begin
            found = 1'b0;
            sel   = 0;
            for (int k = 0; k < N && !found; k++) begin
                if (vld[b*N + (m_ptr[b] + k) % N]) begin
                    sel   = (m_ptr[b] + k) % N;
                    found = 1'b1;
                end
            end
            if (found) begin
                m_lock[b] = 1'b1;
                m_g[b]    = sel;
            end
        end else if (in_hs && gb.last) begin
            m_lock[b] = 1'b0;
            m_ptr[b]  = (g + 1) % N;
        end
    endtask

    // One clock: drive sources on the falling edge, compare 1 ns later.
    task automatic step();
        beat_t bt;
        int    idx;
        @(negedge aclk);
        cyc++;
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < N; p++) begin
                idx = b*N + p;
                if (stall[idx] > 0) stall[idx]--;
                else if (!vld[idx] && src_q[idx].size() > 0 && $urandom_range(99) < vld_pct)
                    vld[idx] = 1'b1;
                bt = vld[idx] ? src_q[idx][0] : '0;
                in_tvalid[b][p]          = vld[idx];
                in_tdata[b][64*p +: 64]  = bt.data;
                in_tdest[b][3*p +: 3]    = bt.dest;
                in_tid[b][TW*p +: TW]    = bt.tid;
                in_tlast[b][p]           = bt.last;
            end
            out_tready[b] = (rdy_mode == 1) ? (cyc % 3 == 0) : ($urandom_range(99) < rdy_pct);
        end
        #1;
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (busy() && n < max) begin
            step();
            n++;
        end
        check("drain_done", 64'(busy()), 64'd0);
        step();
        step();
    endtask

    task automatic check_order(input int b, input string tag);
        check({tag, "_count"}, 64'(order_q[b].size()), 64'(exp_ord.size()));
        for (int i = 0; i < exp_ord.size(); i++) begin
            check($sformatf("%s_pkt%0d", tag, i),
                  64'((i < order_q[b].size()) ? order_q[b][i] : -1), 64'(exp_ord[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        clear_model();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t bt;
        int    bad, cur;
        bit    in_pkt;
        n_cmp = 0; n_err = 0; cyc = 0; pkt_cnt = 0;
        vld_pct = 100; rdy_pct = 100; rdy_mode = 0;
        for (int b = 0; b < 2; b++) begin
            in_tdata[b] = '0; in_tdest[b] = '0; in_tid[b] = '0;
            in_tlast[b] = '0; in_tvalid[b] = '0; out_tready[b] = 1'b0;
        end
        clear_model();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        for (int b = 0; b < 2; b++) begin
            check($sformatf("rst_grant%0d", b), 64'(grant[b]), 64'd0);
            check($sformatf("rst_in_tready%0d", b), 64'(in_tready[b]), 64'd0);
            check($sformatf("rst_out_tvalid%0d", b), 64'(out_tvalid[b]), 64'd0);
        end
        check("rst_out_tdata1", out_tdata[1], 64'd0);

        // Single port: port 2 sends A0, A1, A2.
        for (int k = 0; k < 3; k++) begin
            bt.data = 64'hA0 + 64'(k);
            bt.dest = 3'd5;
            bt.tid  = 4'h7;
            bt.last = (k == 2);
            src_q[2].push_back(bt);
        end
        drain(50);
        check("single_beats", 64'(obs_q[0].size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("single_data%0d", k),
                  (k < obs_q[0].size()) ? obs_q[0][k][63:0] : 64'hX, 64'hA0 + 64'(k));
            check($sformatf("single_last%0d", k),
                  (k < obs_q[0].size()) ? 64'(obs_q[0][k][64]) : 64'hX, 64'(k == 2));
        end
        // Pointer now sits at port 3: it beats port 0 on a tie.
        clear_logs();
        add_pkt(0, 0, 1);
        add_pkt(0, 3, 1);
        drain(50);
        exp_ord = '{3, 0};
        check_order(0, "ptr_after_single");

        // Contention from reset: 2-beat packets on every port.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < N; p++) add_pkt(b, p, 2);
            add_pkt(b, 0, 2);
        end
        drain(200);
        exp_ord = '{0, 1, 2, 3, 0};
        check_order(0, "contention0");
        check_order(1, "contention1");
        bad = 0; in_pkt = 1'b0; cur = 0;
        foreach (obs_q[0][i]) begin
            if (in_pkt && int'(obs_q[0][i][63:60]) != cur) bad++;
            cur    = int'(obs_q[0][i][63:60]);
            in_pkt = !obs_q[0][i][64];
        end
        check("no_interleave", 64'(bad), 64'd0);

        // Backpressure 1,0,0,1,... on a 4-beat packet; port 0 waits behind it.
        clear_logs();
        rdy_mode = 1;
        for (int b = 0; b < 2; b++) begin
            add_pkt(b, 1, 4);
            add_pkt(b, 0, 1);
        end
        drain(100);
        exp_ord = '{1, 0};
        check_order(0, "backpressure0");
        check_order(1, "backpressure1");
        check("backpressure_beats", 64'(obs_q[0].size()), 64'd5);
        rdy_mode = 0;

        // Bubble: port 0 drops tvalid for 5 cycles mid-packet, port 1 waits.
        clear_logs();
        add_pkt(0, 0, 4);
        repeat (3) step();
        stall[0] = 5;
        add_pkt(0, 1, 2);
        drain(100);
        exp_ord = '{0, 1};
        check_order(0, "bubble");

        // Buffered throughput: 8 beats back to back, first 2 cycles after request.
        clear_logs();
        add_pkt(1, 2, 8);
        req_cyc = cyc + 1;
        drain(100);
        check("buf_beats", 64'(out_cyc.size()), 64'd8);
        if (out_cyc.size() == 8) begin
            check("buf_first_latency", 64'(out_cyc[0] - req_cyc), 64'd2);
            check("buf_span", 64'(out_cyc[7] - out_cyc[0]), 64'd7);
        end

        // Random traffic and random stalls on both instances.
        clear_logs();
        vld_pct = 70;
        rdy_pct = 60;
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < N; p++)
                for (int j = 0; j < 6; j++) add_pkt(b, p, int'($urandom_range(1, 5)));
        drain(4000);
        check("random_beats0", 64'(obs_q[0].size()), 64'(loaded[0]));
        check("random_beats1", 64'(obs_q[1].size()), 64'(loaded[1]));

        // Asynchronous reset between edges during beat 2 of 4.
        clear_logs();
        vld_pct = 100;
        rdy_pct = 100;
        for (int b = 0; b < 2; b++) add_pkt(b, 2, 4);
        repeat (3) step();
        check("pre_reset_valid0", 64'(out_tvalid[0]), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            check($sformatf("async_grant%0d", b), 64'(grant[b]), 64'd0);
            check($sformatf("async_in_tready%0d", b), 64'(in_tready[b]), 64'd0);
            check($sformatf("async_out_tvalid%0d", b), 64'(out_tvalid[b]), 64'd0);
        end
        clear_model();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        for (int b = 0; b < 2; b++) begin
            add_pkt(b, 3, 2);
            add_pkt(b, 0, 2);
        end
        drain(100);
        exp_ord = '{0, 3};
        check_order(0, "after_reset0");
        check_order(1, "after_reset1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bsc_axiu_stream_rr_arbiter.md
# bsc_axiu_stream_rr_arbiter

Packet-atomic round-robin arbiter that merges NUM_PORTS AXI-Stream task/message streams into one shared output stream. It sits between per-accelerator handshake-to-stream adapters and the single interconnect stream toward the scheduler/manager. The grant is held for a whole packet, from the first beat to the beat with tlast, so beats from different accelerators never interleave. An optional registered skid stage closes timing on the shared output.

## Interface
- NUM_PORTS, default 4: number of input streams, 2..16.
- TID_WIDTH, default 4: width of tid on all ports.
- USE_BUFFER, default 0:
  - 0: mux drives the output combinationally.
  - 1: a 2-entry skid buffer sits between the mux and the output.
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- in_tdata  in  NUM_PORTS*64  port i occupies bits [64*i+63:64*i].
- in_tdest  in  NUM_PORTS*3  port i occupies bits [3*i+2:3*i].
- in_tid  in  NUM_PORTS*TID_WIDTH  per-port tid, forwarded unchanged.
- in_tlast  in  NUM_PORTS  per-port end of packet.
- in_tvalid  in  NUM_PORTS  per-port valid.
- in_tready  out  NUM_PORTS  per-port ready.
- out_tdata  out  64
- out_tdest  out  3
- out_tid  out  TID_WIDTH
- out_tlast  out  1
- out_tvalid  out  1
- out_tready  in  1
- grant  out  NUM_PORTS  one-hot port currently owning the output; all zero when idle.

## Operation
- FSM states: IDLE and LOCKED.
- Round-robin pointer `ptr` (log2 NUM_PORTS bits) gives the highest-priority port.
- IDLE:
  - in_tready is all zero; grant is all zero.
  - If any in_tvalid is set, select the first set bit scanning ptr, ptr+1, …, wrapping modulo NUM_PORTS.
  - Register that port as one-hot `grant` and go to LOCKED.
- LOCKED, granted port g:
  - The mux steers port g's data/dest/tid/last/valid to the mux output.
  - in_tready[g] = downstream ready. This is out_tready when USE_BUFFER=0, or skid-not-full when USE_BUFFER=1.
  - All other in_tready bits are 0.
- Release: on a handshake of port g with tlast=1, go to IDLE and set ptr = (g+1) mod NUM_PORTS.
- tid and tdest are never modified or generated; they pass through from the granted port.
- The grant never changes mid-packet, regardless of in_tvalid activity on other ports.
- In LOCKED, deassertion of in_tvalid[g] mid-packet is legal; the arbiter waits and keeps the grant.
- Skid stage (USE_BUFFER=1):
  - 2-entry FIFO, entries in order.
  - out_tvalid = FIFO non-empty.
  - Upstream ready = FIFO not full.
  - Must sustain 1 beat/cycle when out_tready is held at 1.
  - A simultaneous push and pop with 1 entry stored keeps the occupancy at 1.
- Reset (asynchronous, any state, mid-packet included):
  - state=IDLE, ptr=0, grant=0.
  - Skid FIFO emptied.
  - out_tvalid=0 and in_tready=0 immediately.
  - A partially transferred packet is abandoned; no recovery is attempted.

## Timing
- Arbitration costs one cycle per packet. A valid sampled in IDLE at edge N gives grant and in_tready at edge N+1.
- USE_BUFFER=0:
  - First beat appears on out_* in the cycle after the IDLE decision.
  - Mid-packet latency is 0 cycles (combinational path tvalid→out_tvalid and out_tready→in_tready).
- USE_BUFFER=1: one more cycle of latency; no combinational path between input and output handshake signals.
- Throughput: 1 beat/cycle inside a packet. A packet of B beats occupies B+1 cycles minimum (B beats plus the IDLE cycle).
- Single-beat packets from all ports back to back: each port is served every 2*NUM_PORTS cycles.
- Reset values: out_tvalid=0, in_tready=0, grant=0. out_tdata/tdest/tid/tlast are don't-care while out_tvalid=0 (zero after reset when USE_BUFFER=1).

## Test plan
- Single port, NUM_PORTS=4, USE_BUFFER=0: port 2 sends 3 beats 0xA0..0xA2 with tlast on the third.
  - Required: grant=4'b0100 one cycle after valid; out_tdata sequence A0, A1, A2; tlast only on A2; grant=0 after the last beat; ptr=3.
- Contention: all 4 ports hold 2-beat packets from reset.
  - Required: output packet order is ports 0, 1, 2, 3, then 0 again.
  - No interleaving of beats from different ports.
  - out_tid matches each port's tid.
- Backpressure: out_tready toggles 1,0,0,1,… during a 4-beat packet.
  - Required: no beat lost or duplicated; in_tready[g] mirrors out_tready (USE_BUFFER=0).
  - A request from another port stays ungranted until tlast.
- Bubble in packet: granted port drops tvalid for 5 cycles mid-packet while port 1 is valid.
  - Required: grant does not move; the packet completes; port 1 is granted next.
- USE_BUFFER=1 throughput: 8-beat packet with out_tready=1 constantly.
  - Required: 8 consecutive output beats; first beat 2 cycles after the request.
  - Random out_tready stalls give an in-order stream with no loss.
- Asynchronous reset: assert aresetn=0 between clock edges during beat 2 of 4.
  - Required: out_tvalid, in_tready and grant go to 0 before the next edge.
  - After release, port 0 has priority and a new packet is arbitrated normally.
